// File: rtl/debug_output_pkg.sv
// Shared type codes and per-pin configuration record for the GPIO debug tap.
package debug_output_pkg;

  localparam int TYPE_W  = 8;
  localparam int VALUE_W = 16;

  localparam logic [TYPE_W-1:0] DBG_NONE      = 8'h00;
  localparam logic [TYPE_W-1:0] DBG_BASE_SIG  = 8'h01;
  localparam logic [TYPE_W-1:0] DBG_THERMO    = 8'h02;
  localparam logic [TYPE_W-1:0] DBG_FORCE_FAN = 8'h03;
  localparam logic [TYPE_W-1:0] DBG_SYNC      = 8'h04;
  localparam logic [TYPE_W-1:0] DBG_STM_IDX   = 8'h05;
  localparam logic [TYPE_W-1:0] DBG_PWM_OUT   = 8'h06;
  localparam logic [TYPE_W-1:0] DBG_SYS_TIME  = 8'h07;
  localparam logic [TYPE_W-1:0] DBG_DIRECT    = 8'h08;

  typedef struct packed {
    logic [TYPE_W-1:0]  dtype;
    logic [VALUE_W-1:0] value;
  } dbg_cfg_t;

endpackage

// File: rtl/debug_output_pulse_stretcher.sv
// Retriggerable pulse stretcher: OUT reflects whether the counter is nonzero
// after the coming edge, so a registered consumer sees exactly LEN high cycles.
module pulse_stretcher #(
  parameter int STRETCH_W = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 TRIG,
  input  logic [STRETCH_W-1:0] LEN,
  input  logic                 CLR,
  output logic                 OUT
);

  logic [STRETCH_W-1:0] cnt;
  logic [STRETCH_W-1:0] cnt_d;

  always_comb begin
    // NOTE: default first so every path assigns cnt_d and no latch is inferred.
    cnt_d = cnt;
    if (CLR) begin
      cnt_d = '0;
    end else if (TRIG) begin
      cnt_d = (LEN == '0) ? STRETCH_W'(1) : LEN;
    end else if (cnt != '0) begin
      cnt_d = cnt - STRETCH_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: non-blocking assignment for state so all flops update together.
    if (RST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_d;
    end
  end

  assign OUT = (cnt_d != '0);

endmodule

// File: rtl/debug_output.sv
// GPIO debug tap: each pin shows a selectable internal signal; configuration
// written by the controller takes effect only at a PWM period boundary.
module debug_output
  import debug_output_pkg::*;
#(
  parameter int DEPTH     = 249,
  parameter int NUM_GPIO  = 4,
  parameter int STRETCH_W = 16
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [8:0]                  TIME_CNT,
  input  logic                        UPDATE,
  input  logic                        SYNC,
  input  logic                        THERMO,
  input  logic                        FORCE_FAN,
  input  logic                        OP_MODE,
  input  logic [15:0]                 STM_IDX,
  input  logic [63:0]                 SYS_TIME,
  input  logic [DEPTH-1:0]            PWM_OUT,
  input  logic [TYPE_W*NUM_GPIO-1:0]  DBG_TYPE,
  input  logic [VALUE_W*NUM_GPIO-1:0] DBG_VALUE,
  input  logic                        DBG_SET,
  output logic [NUM_GPIO-1:0]         GPIO_OUT
);

  localparam logic [VALUE_W-1:0] DEPTH_V = VALUE_W'(DEPTH);

  dbg_cfg_t            set_cfg     [NUM_GPIO];
  dbg_cfg_t            pending_cfg [NUM_GPIO];
  dbg_cfg_t            active_cfg  [NUM_GPIO];
  dbg_cfg_t            apply_cfg   [NUM_GPIO];
  logic                pending_vld;
  logic                apply;
  logic [NUM_GPIO-1:0] sync_busy;
  logic [NUM_GPIO-1:0] pin_d;

  // A strobe coincident with UPDATE bypasses the pending stage.
  always_comb begin
    for (int i = 0; i < NUM_GPIO; i++) begin
      set_cfg[i].dtype = DBG_TYPE[i*TYPE_W +: TYPE_W];
      set_cfg[i].value = DBG_VALUE[i*VALUE_W +: VALUE_W];
      apply_cfg[i]     = DBG_SET ? set_cfg[i] : pending_cfg[i];
    end
  end

  assign apply = UPDATE && (DBG_SET || pending_vld);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pending_vld <= 1'b0;
      // NOTE: these arrays are plain flops, so they are reset like any other state.
      for (int i = 0; i < NUM_GPIO; i++) begin
        pending_cfg[i] <= '{dtype: DBG_NONE, value: '0};
        active_cfg[i]  <= '{dtype: DBG_NONE, value: '0};
      end
    end else begin
      if (DBG_SET && !UPDATE) begin
        pending_cfg <= set_cfg;
        pending_vld <= 1'b1;
      end
      if (apply) begin
        active_cfg  <= apply_cfg;
        pending_vld <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NUM_GPIO; g++) begin : g_pin
    logic trig;
    logic clr;

    assign trig = SYNC && (active_cfg[g].dtype == DBG_SYNC);
    assign clr  = apply && (apply_cfg[g].dtype != active_cfg[g].dtype);

    pulse_stretcher #(
      .STRETCH_W(STRETCH_W)
    ) u_stretch (
      .CLK (CLK),
      .RST (RST),
      .TRIG(trig),
      .LEN (active_cfg[g].value[STRETCH_W-1:0]),
      .CLR (clr),
      .OUT (sync_busy[g])
    );
  end

  always_comb begin
    pin_d = '0;
    for (int i = 0; i < NUM_GPIO; i++) begin
      case (active_cfg[i].dtype)
        DBG_BASE_SIG:  pin_d[i] = (TIME_CNT < 9'd256);
        DBG_THERMO:    pin_d[i] = THERMO;
        DBG_FORCE_FAN: pin_d[i] = FORCE_FAN;
        DBG_SYNC:      pin_d[i] = sync_busy[i];
        DBG_STM_IDX:   pin_d[i] = OP_MODE && (STM_IDX == active_cfg[i].value);
        DBG_PWM_OUT:   pin_d[i] = (active_cfg[i].value < DEPTH_V) &&
                                  PWM_OUT[active_cfg[i].value[7:0]];
        DBG_SYS_TIME:  pin_d[i] = SYS_TIME[active_cfg[i].value[5:0]];
        DBG_DIRECT:    pin_d[i] = active_cfg[i].value[0];
        default:       pin_d[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      GPIO_OUT <= '0;
    end else begin
      GPIO_OUT <= pin_d;
    end
  end

endmodule

// File: doc/debug_output.md
Name: debug_output

Overview:
- Generalised GPIO debug tap for the top level, replacing the fixed two-pin logic (base-signal pin plus one PWM-channel tap).
- Drives NUM_GPIO pins, each independently configured by a type/value pair written by the controller.
- A new configuration is applied only at a PWM period boundary (UPDATE), so pins never glitch mid-period.
- Adds stretched sync pulses, STM index match, sys_time bit and direct drive.

Parameters:
DEPTH, 249, number of transducer PWM channels available for tapping
NUM_GPIO, 4, number of debug output pins
STRETCH_W, 16, width of the sync pulse-stretch counter

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous reset, active-high
TIME_CNT  in  9  PWM period counter (0..511)
UPDATE  in  1  one-cycle pulse at PWM period boundary
SYNC  in  1  one-cycle EtherCAT sync pulse (synchronised)
THERMO  in  1  thermal sensor input
FORCE_FAN  in  1  fan force flag
OP_MODE  in  1  0 normal, 1 STM
STM_IDX  in  16  current STM index
SYS_TIME  in  64  system time
PWM_OUT  in  1 x DEPTH  transducer PWM outputs
DBG_TYPE  in  8 x NUM_GPIO  requested type per pin
DBG_VALUE  in  16 x NUM_GPIO  requested argument per pin
DBG_SET  in  1  one-cycle strobe; capture DBG_TYPE/DBG_VALUE
GPIO_OUT  out  1 x NUM_GPIO  debug pins, registered

Behaviour:
- Reset (async, RST=1): GPIO_OUT all 0; active and pending types NONE; values 0; pending flag 0; stretch counters 0.
- Config path:
  - DBG_SET captures all pairs into pending regs and sets the pending flag.
  - On UPDATE with the pending flag set, pending is copied to active and the flag is cleared.
  - DBG_SET and UPDATE in the same cycle: the new values go straight to active and the flag stays 0.
  - Multiple DBG_SET before UPDATE: last write wins.
- Per-pin function of the active type, evaluated each cycle; GPIO_OUT is registered, so latency is 1 cycle from input to pin:
  - 0x00 NONE -> 0.
  - 0x01 BASE_SIGNAL -> TIME_CNT < 256.
  - 0x02 THERMO -> THERMO.
  - 0x03 FORCE_FAN -> FORCE_FAN.
  - 0x04 SYNC -> stretched pulse, described below.
  - 0x05 STM_IDX -> OP_MODE==1 && STM_IDX==VALUE.
  - 0x06 PWM_OUT -> PWM_OUT[VALUE[7:0]]; VALUE[15:0] >= DEPTH -> 0.
  - 0x07 SYS_TIME_BIT -> SYS_TIME[VALUE[5:0]].
  - 0x08 DIRECT -> VALUE[0].
  - Any other code -> 0.
- SYNC stretch, per pin:
  - SYNC=1 loads the counter with max(VALUE,1) and the pin goes high the next cycle.
  - The counter decrements each cycle while nonzero; the pin is high while the counter is nonzero, so the pulse width is max(VALUE,1) cycles.
  - SYNC arriving while the counter is nonzero reloads it (retrigger, no gap).
  - The counter clears when a config apply changes that pin's type.
- Reset mid-operation: everything returns to reset values immediately; the pending config is lost.
- No combinational path from inputs to GPIO_OUT.

Decomposition:
- Package debug_output_pkg:
  - Type code constants: DBG_NONE, DBG_BASE_SIG, DBG_THERMO, DBG_FORCE_FAN, DBG_SYNC, DBG_STM_IDX, DBG_PWM_OUT, DBG_SYS_TIME, DBG_DIRECT.
  - Type code width localparam (8).
- Sub-module pulse_stretcher (params STRETCH_W; ports CLK, RST, TRIG, LEN, CLR, OUT), instantiated once per pin by generate.

Test Plan:
- Reset then release with no DBG_SET; toggle all inputs -> GPIO_OUT stays 0 on every pin.
- DBG_SET pin0=BASE_SIGNAL mid-period, UPDATE 100 cycles later -> pin0 stays 0 until the cycle after UPDATE, then equals TIME_CNT<256 delayed 1 cycle (high 256, low 256).
- Pin1=PWM_OUT value 10 -> pin1 equals PWM_OUT[10] delayed 1 cycle; value 300 (>=DEPTH 249) -> pin1 constant 0.
- Pin2=SYNC value 5:
  - SYNC pulse -> pin high exactly 5 cycles.
  - Second SYNC 3 cycles after the first -> pin high 8 cycles continuous.
  - Value 0 -> pin high 1 cycle.
- Pin3=STM_IDX value 7, OP_MODE=1, STM_IDX sweeps 0..15 -> pin high only for the idx 7 cycle (+1 latency); OP_MODE=0 -> never high.
- DBG_SET coincident with UPDATE -> new config visible next cycle. Two DBG_SETs (DIRECT 1, then DIRECT 0) before UPDATE -> pin 0 after UPDATE. RST asserted mid-pulse -> pin 0 immediately, config back to NONE.
